// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the data-memory responder
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD,
        OP_STORE,
        OP_ILLEGAL
    } op_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/sp_ram.sv
// rtl/sp_ram.sv - single-port synchronous 32-bit RAM with registered read data, no reset
module sp_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    // Read data only moves on a read so it can be held between loads.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_idx] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_idx];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed load/store responder with programmable wait states
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_ce,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic              mem_err,
    output logic              busy
);

    localparam int OFS_W = $clog2(WORD_BYTES);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    op_t               r_op;
    op_t               w_op_in;
    logic [IDX_W-1:0]  r_idx;
    logic [31:0]       r_wdata;
    logic              r_zero;
    logic              w_accept;
    logic              w_access;
    logic              w_misaligned;
    logic              w_in_range;
    logic [31:0]       w_ram_rdata;

    assign w_accept     = (r_state == IDLE) && ram_ce && (mem_read || mem_write);
    assign w_access     = (r_state == WAIT) && (r_cnt == 4'd0);
    assign w_misaligned = mem_addr[OFS_W-1:0] != '0;
    assign w_in_range   = 32'(mem_addr[ADDR_W-1:OFS_W]) < 32'(DEPTH_WORDS);

    always_comb begin
        w_op_in = OP_ILLEGAL;
        if (!(mem_read && mem_write) && !w_misaligned && w_in_range) begin
            w_op_in = mem_write ? OP_STORE : OP_LOAD;
        end
    end

    // WAIT always lasts at least one cycle: the synchronous RAM access
    // happens on the edge leaving WAIT so its data is ready in RESP.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_nxt = WAIT;
            WAIT:    if (r_cnt == 4'd0) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_op    <= OP_LOAD;
            r_idx   <= '0;
            r_wdata <= 32'h0;
            r_zero  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt   <= 4'(WAIT_STATES);
                r_op    <= w_op_in;
                r_idx   <= mem_addr[OFS_W +: IDX_W];
                r_wdata <= mem_wdata;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access && (r_op == OP_ILLEGAL)) begin
                r_zero <= 1'b1;
            end else if (w_access && (r_op == OP_LOAD)) begin
                r_zero <= 1'b0;
            end
        end
    end

    sp_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_access && (r_op == OP_STORE)),
        .i_re    (w_access && (r_op == OP_LOAD)),
        .i_idx   (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Zero-forcing covers both reset and error responses without resetting the RAM.
    assign mem_rdata = r_zero ? 32'h0 : w_ram_rdata;
    assign mem_ready = (r_state == RESP);
    assign mem_err   = (r_state == RESP) && (r_op == OP_ILLEGAL);
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench over three wait-state settings
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst   [3];
    logic        ce    [3];
    logic        rd    [3];
    logic        wr    [3];
    logic [15:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        ready [3];
    logic        err   [3];
    logic        busy  [3];

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mdl [int];
    logic [31:0] exp_rd [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder #(
            .ADDR_W      (16),
            .DEPTH_WORDS (1024),
            .WAIT_STATES (g == 0 ? 0 : (g == 1 ? 1 : 3))
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .ram_ce    (ce[g]),
            .mem_read  (rd[g]),
            .mem_write (wr[g]),
            .mem_addr  (addr[g]),
            .mem_wdata (wdata[g]),
            .mem_rdata (rdata[g]),
            .mem_ready (ready[g]),
            .mem_err   (err[g]),
            .busy      (busy[g])
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    function automatic logic is_err(input logic r, input logic w, input logic [15:0] a);
        return (r && w) || (a % 4 != 0) || (a / 4 >= 1024);
    endfunction

    // Predict the response from the access rules and update the reference memory.
    task automatic predict(input int k, input logic r, input logic w, input logic [15:0] a,
                           input logic [31:0] d, output logic e_err);
        int key;
        key   = k * 65536 + int'(a / 4);
        e_err = is_err(r, w, a);
        if (e_err) begin
            exp_rd[k] = 32'h0;
        end else if (w) begin
            mdl[key] = d;
        end else begin
            exp_rd[k] = mdl.exists(key) ? mdl[key] : 32'hxxxxxxxx;
        end
    endtask

    task automatic run_req(input int k, input logic r, input logic w, input logic [15:0] a,
                           input logic [31:0] d, input bit scr,
                           output int lat, output int bcnt, output logic e,
                           output logic [31:0] rdv, output logic rdy_after, output logic busy_after);
        @(negedge clk);
        ce[k] = 1'b1; rd[k] = r; wr[k] = w; addr[k] = a; wdata[k] = d;
        @(posedge clk);
        lat = -1; bcnt = 0; e = 1'b0; rdv = 32'h0;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            @(negedge clk);
            if (busy[k]) bcnt++;
            if (ready[k]) begin
                lat = c; e = err[k]; rdv = rdata[k];
            end
            if (scr) begin
                ce[k] = 1'b1; rd[k] = 1'($urandom); wr[k] = 1'($urandom);
                addr[k] = 16'($urandom); wdata[k] = $urandom;
            end else begin
                ce[k] = 1'b0;
            end
        end
        @(negedge clk);
        rdy_after = ready[k]; busy_after = busy[k];
        ce[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0;
    endtask

    task automatic check_req(input string name, input int k, input logic r, input logic w,
                             input logic [15:0] a, input logic [31:0] d, input bit scr);
        int lat, bcnt;
        logic e, ra, ba, e_err;
        logic [31:0] rdv;
        predict(k, r, w, a, d, e_err);
        run_req(k, r, w, a, d, scr, lat, bcnt, e, rdv, ra, ba);
        n_chk++;
        if (lat !== ws_of(k) + 1) begin
            n_err++; $display("FAIL %s k=%0d latency got %0d exp %0d", name, k, lat, ws_of(k) + 1);
        end
        n_chk++;
        if (bcnt !== ws_of(k) + 2) begin
            n_err++; $display("FAIL %s k=%0d busy cycles got %0d exp %0d", name, k, bcnt, ws_of(k) + 2);
        end
        n_chk++;
        if (e !== e_err) begin
            n_err++; $display("FAIL %s k=%0d mem_err got %b exp %b", name, k, e, e_err);
        end
        n_chk++;
        if (rdv !== exp_rd[k]) begin
            n_err++; $display("FAIL %s k=%0d mem_rdata got %h exp %h", name, k, rdv, exp_rd[k]);
        end
        n_chk++;
        if (ra !== 1'b0 || ba !== 1'b0) begin
            n_err++; $display("FAIL %s k=%0d after RESP ready=%b busy=%b exp 0 0", name, k, ra, ba);
        end
    endtask

    task automatic test_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (ready[k] !== 1'b0 || err[k] !== 1'b0 || busy[k] !== 1'b0 || rdata[k] !== 32'h0) begin
                n_err++;
                $display("FAIL reset k=%0d ready=%b err=%b busy=%b rdata=%h exp all 0",
                         k, ready[k], err[k], busy[k], rdata[k]);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    endtask

    task automatic test_store_load();
        check_req("store_beef", 1, 1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 1'b0);
        check_req("load_beef", 1, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b0);
    endtask

    task automatic test_zero_wait();
        check_req("store_five", 0, 1'b0, 1'b1, 16'h0000, 32'h00000005, 1'b0);
        check_req("load_five", 0, 1'b1, 1'b0, 16'h0000, 32'h0, 1'b0);
    endtask

    task automatic test_errors();
        check_req("err_misaligned", 1, 1'b1, 1'b0, 16'h0013, 32'h0, 1'b0);
        check_req("err_range", 1, 1'b1, 1'b0, 16'h1000, 32'h0, 1'b0);
        check_req("err_both", 1, 1'b1, 1'b1, 16'h0010, 32'h11111111, 1'b0);
        check_req("err_followup", 1, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b0);
    endtask

    task automatic test_boundary();
        check_req("last_word_st", 1, 1'b0, 1'b1, 16'h0FFC, 32'h5A5AA5A5, 1'b0);
        check_req("last_word_ld", 1, 1'b1, 1'b0, 16'h0FFC, 32'h0, 1'b0);
        check_req("range_store", 1, 1'b0, 1'b1, 16'h1000, 32'h77777777, 1'b0);
    endtask

    task automatic test_ce_low();
        int seen;
        check_req("ce_preload", 1, 1'b0, 1'b1, 16'h0020, 32'h11112222, 1'b0);
        @(negedge clk);
        ce[1] = 1'b0; wr[1] = 1'b1; rd[1] = 1'b0; addr[1] = 16'h0020; wdata[1] = 32'h12345678;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ready[1] || busy[1]) seen++;
        end
        wr[1] = 1'b0;
        n_chk++;
        if (seen !== 0) begin
            n_err++; $display("FAIL ce_low activity cycles got %0d exp 0", seen);
        end
        check_req("ce_reload", 1, 1'b1, 1'b0, 16'h0020, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid();
        check_req("rst_preload", 2, 1'b0, 1'b1, 16'h0040, 32'h0A0A0A0A, 1'b0);
        @(negedge clk);
        ce[2] = 1'b1; wr[2] = 1'b1; rd[2] = 1'b0; addr[2] = 16'h0040; wdata[2] = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        ce[2] = 1'b0; wr[2] = 1'b0;
        n_chk++;
        if (busy[2] !== 1'b1) begin
            n_err++; $display("FAIL rst_mid accept busy got %b exp 1", busy[2]);
        end
        @(posedge clk);
        #1 rst[2] = 1'b1;
        #1;
        n_chk++;
        if (ready[2] !== 1'b0 || err[2] !== 1'b0 || busy[2] !== 1'b0 || rdata[2] !== 32'h0) begin
            n_err++;
            $display("FAIL rst_mid outputs ready=%b err=%b busy=%b rdata=%h exp all 0",
                     ready[2], err[2], busy[2], rdata[2]);
        end
        exp_rd[2] = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst[2] = 1'b0;
        check_req("rst_reload", 2, 1'b1, 1'b0, 16'h0040, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        int sel;
        logic r, w;
        logic [15:0] a;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) begin
                check_req("rnd_fill", k, 1'b0, 1'b1, 16'(i * 4), $urandom, 1'b1);
            end
            for (int i = 0; i < 40; i++) begin
                sel = $urandom_range(0, 9);
                a   = 16'($urandom_range(0, 15) * 4);
                r   = 1'b0; w = 1'b0;
                if (sel < 4) r = 1'b1;
                else if (sel < 7) w = 1'b1;
                else if (sel == 7) begin r = 1'b1; a = a | 16'($urandom_range(1, 3)); end
                else if (sel == 8) begin r = 1'b1; a = 16'($urandom_range(1024, 16383) * 4); end
                else begin r = 1'b1; w = 1'b1; end
                check_req("rnd_op", k, r, w, a, $urandom, 1'b1);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; ce[k] = 1'b0; rd[k] = 1'b0; wr[k] = 1'b0;
            addr[k] = 16'h0; wdata[k] = 32'h0; exp_rd[k] = 32'h0;
        end
        test_reset();
        test_zero_wait();
        test_store_load();
        test_errors();
        test_boundary();
        test_ce_low();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
